// File: rtl/data_memory_stage_pkg.sv
// Shared encodings, stage control payload and helpers for the DM pipeline stage.
package data_memory_stage_pkg;

    localparam logic DM_SZ_BYTE  = 1'b0;
    localparam logic DM_SZ_WORD  = 1'b1;
    localparam logic DM_RW_LOAD  = 1'b0;
    localparam logic DM_RW_STORE = 1'b1;

    typedef struct packed {
        logic valid;
        logic size;
        logic sign;
        logic mux_sel;
        logic misalign;
        logic oob;
    } dm_ctl_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port, byte-lane write enable, synchronous-read RAM (read-first on writes).
module dm_ram
    import data_memory_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                      clka,
    input  logic                      ena,
    input  logic [DATA_W/8-1:0]       wea,
    input  logic [clog2(DEPTH)-1:0]   addra,
    input  logic [DATA_W-1:0]         dina,
    output logic [DATA_W-1:0]         douta
);

    localparam int unsigned LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clka) begin
        if (ena) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
            end
            douta <= mem[addra];
        end
    end

endmodule

// File: rtl/data_memory_stage.sv
// MIPS DM stage: byte/word load-store on a sync RAM, ALU bypass, error flags, stall hold.
module data_memory_stage
    import data_memory_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    input  logic              stall,
    input  logic [ADDR_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_size_ex,
    input  logic              mem_sign_ex,
    input  logic              mem_mux_sel_ex,
    output logic [DATA_W-1:0] ans_dm,
    output logic              valid_dm,
    output logic              misalign_err,
    output logic              oob_err
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned LB    = clog2(LANES);
    localparam int unsigned IDX_W = clog2(DEPTH);
    localparam int unsigned WI_W  = ADDR_W - LB;

    logic [WI_W-1:0]   word_idx;
    logic [LB-1:0]     lane;
    logic              misalign;
    logic              oob;
    logic              req;
    logic              acc;
    logic [LANES-1:0]  wea;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    dm_ctl_t           ctl_d;
    dm_ctl_t           ctl_q;
    logic [DATA_W-1:0] alu_q;
    logic [LB-1:0]     lane_q;
    logic [DATA_W-1:0] hold_q;
    logic              held_q;
    logic [DATA_W-1:0] cur_data;
    logic [7:0]        lane_byte;
    logic [DATA_W-1:0] ans_dm_c;

    assign word_idx = ans_ex[ADDR_W-1:LB];
    assign lane     = ans_ex[LB-1:0];
    assign misalign = (mem_size_ex == DM_SZ_WORD) && (lane != '0);
    assign oob      = 32'(word_idx) >= DEPTH;
    assign req      = valid_ex & mem_en_ex;
    // Reset gating keeps an aborted access from touching the array.
    assign acc      = req & ~stall & ~misalign & ~oob & reset;

    // Lane enables and write data; byte stores replicate the low byte across lanes.
    always_comb begin
        wea  = '0;
        dina = DM_data;
        if (acc && (mem_rw_ex == DM_RW_STORE)) begin
            if (mem_size_ex == DM_SZ_WORD) begin
                wea = '1;
            end else begin
                wea  = LANES'(1) << lane;
                dina = {LANES{DM_data[7:0]}};
            end
        end
    end

    dm_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clka  (clk),
        .ena   (acc),
        .wea   (wea),
        .addra (IDX_W'(word_idx)),
        .dina  (dina),
        .douta (douta)
    );

    always_comb begin
        ctl_d          = '0;
        ctl_d.valid    = valid_ex;
        ctl_d.size     = mem_size_ex;
        ctl_d.sign     = mem_sign_ex;
        ctl_d.mux_sel  = mem_mux_sel_ex;
        ctl_d.misalign = req & misalign;
        ctl_d.oob      = req & oob;
    end

    // Stage registers advance only when not stalled; the hold register tracks read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_q  <= '0;
            alu_q  <= '0;
            lane_q <= '0;
            hold_q <= '0;
            held_q <= 1'b0;
        end else begin
            held_q <= stall;
            hold_q <= cur_data;
            if (!stall) begin
                ctl_q  <= ctl_d;
                alu_q  <= DATA_W'(ans_ex);
                lane_q <= lane;
            end
        end
    end

    assign cur_data  = held_q ? hold_q : douta;
    assign lane_byte = cur_data[{lane_q, 3'b000} +: 8];

    always_comb begin
        ans_dm_c = alu_q;
        if (ctl_q.mux_sel) begin
            if (ctl_q.misalign || ctl_q.oob) begin
                ans_dm_c = '0;
            end else if (ctl_q.size == DM_SZ_WORD) begin
                ans_dm_c = cur_data;
            end else begin
                ans_dm_c = {{(DATA_W-8){ctl_q.sign & lane_byte[7]}}, lane_byte};
            end
        end
    end

    assign ans_dm       = ans_dm_c;
    assign valid_dm     = ctl_q.valid;
    assign misalign_err = ctl_q.misalign;
    assign oob_err      = ctl_q.oob;

endmodule

// File: tb/tb_data_memory_stage.sv
// Scoreboard bench for data_memory_stage (DATA_W=16, ADDR_W=16, DEPTH=1024).
`timescale 1ns/1ps
module tb_data_memory_stage;

    typedef struct {
        string       tag;
        logic [15:0] ans;
        bit          chk_ans;
        logic        valid;
        logic        mis;
        logic        oob;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        valid_ex;
    logic        stall;
    logic [15:0] ans_ex;
    logic [15:0] dm_data;
    logic        mem_en_ex;
    logic        mem_rw_ex;
    logic        mem_size_ex;
    logic        mem_sign_ex;
    logic        mem_mux_sel_ex;
    logic [15:0] ans_dm;
    logic        valid_dm;
    logic        misalign_err;
    logic        oob_err;

    int          checks   = 0;
    int          failures = 0;
    int          n_ops    = 0;
    sb_t         sb[$];
    sb_t         last;
    logic [15:0] mem_m [1024];

    data_memory_stage #(
        .DATA_W (16),
        .ADDR_W (16),
        .DEPTH  (1024)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_ex       (valid_ex),
        .stall          (stall),
        .ans_ex         (ans_ex),
        .DM_data        (dm_data),
        .mem_en_ex      (mem_en_ex),
        .mem_rw_ex      (mem_rw_ex),
        .mem_size_ex    (mem_size_ex),
        .mem_sign_ex    (mem_sign_ex),
        .mem_mux_sel_ex (mem_mux_sel_ex),
        .ans_dm         (ans_dm),
        .valid_dm       (valid_dm),
        .misalign_err   (misalign_err),
        .oob_err        (oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one slot at the negedge and push what the stage must show after the next posedge.
    task automatic drive(input logic v, input logic st, input logic en, input logic rw,
                         input logic sz, input logic sg, input logic ms,
                         input logic [15:0] a, input logic [15:0] d);
        sb_t        e;
        logic       mis;
        logic       oob;
        logic       fault;
        int         idx;
        logic [7:0] b;
        @(negedge clk);
        valid_ex = v; stall = st; mem_en_ex = en; mem_rw_ex = rw;
        mem_size_ex = sz; mem_sign_ex = sg; mem_mux_sel_ex = ms;
        ans_ex = a; dm_data = d;
        n_ops++;
        if (st) begin
            sb.push_back(last);
        end else begin
            idx   = int'(a[15:1]);
            mis   = v & en & sz & a[0];
            oob   = v & en & (idx >= 1024);
            fault = mis | oob;
            e.tag = $sformatf("op%0d", n_ops);
            e.valid = v; e.mis = mis; e.oob = oob;
            e.chk_ans = 1'b1;
            e.ans = a;
            if (ms) begin
                if (fault) begin
                    e.ans = 16'h0000;
                end else if (v && en && !rw) begin
                    if (sz) begin
                        e.ans = mem_m[idx];
                    end else begin
                        b = a[0] ? mem_m[idx][15:8] : mem_m[idx][7:0];
                        e.ans = {{8{sg & b[7]}}, b};
                    end
                end else begin
                    e.chk_ans = 1'b0;
                end
            end
            if (v && en && rw && !fault) begin
                if (sz)        mem_m[idx] = d;
                else if (a[0]) mem_m[idx][15:8] = d[7:0];
                else           mem_m[idx][7:0]  = d[7:0];
            end
            last = e;
            sb.push_back(e);
        end
    endtask

    task automatic peek(input string tag, input logic [15:0] exp);
        @(posedge clk);
        #3;
        chk(tag, ans_dm, exp);
    endtask

    always begin : monitor
        sb_t e;
        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_valid"}, valid_dm, e.valid);
            chk({e.tag, "_mis"}, misalign_err, e.mis);
            chk({e.tag, "_oob"}, oob_err, e.oob);
            if (e.chk_ans) chk({e.tag, "_ans"}, ans_dm, e.ans);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; valid_ex = 1'b0; stall = 1'b0; ans_ex = '0; dm_data = '0;
        mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_size_ex = 1'b0; mem_sign_ex = 1'b0;
        mem_mux_sel_ex = 1'b0;
        #3;
        chk("rst_ans", ans_dm, 16'h0000);
        chk("rst_valid", valid_dm, 1'b0);
        chk("rst_mis", misalign_err, 1'b0);
        chk("rst_oob", oob_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // word store then back-to-back load
        drive(1, 0, 1, 1, 1, 0, 0, 16'h0010, 16'h1234);
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0010, 16'h0000);
        peek("t1_word_ld", 16'h1234);

        // byte lanes
        drive(1, 0, 1, 1, 1, 0, 0, 16'h0020, 16'h5566);
        drive(1, 0, 1, 1, 0, 0, 0, 16'h0021, 16'h77AB);
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0020, 16'h0000);
        peek("t2_word_after_byte", 16'hAB66);
        drive(1, 0, 1, 0, 0, 1, 1, 16'h0021, 16'h0000);
        peek("t2_byte_signed", 16'hFFAB);
        drive(1, 0, 1, 0, 0, 0, 1, 16'h0021, 16'h0000);
        peek("t2_byte_unsigned", 16'h00AB);
        drive(1, 0, 1, 0, 0, 1, 1, 16'h0020, 16'h0000);
        peek("t2_byte_lane0", 16'h0066);

        // errors and range boundary
        drive(1, 0, 1, 1, 1, 0, 0, 16'h0011, 16'hDEAD);
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0010, 16'h0000);
        peek("t3_misalign_no_write", 16'h1234);
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0800, 16'h0000);
        peek("t3_oob_zero", 16'h0000);
        drive(1, 0, 1, 0, 0, 1, 1, 16'h0801, 16'h0000);
        drive(1, 0, 1, 1, 1, 0, 0, 16'h07FE, 16'h0F0F);
        drive(1, 0, 1, 0, 1, 0, 1, 16'h07FE, 16'h0000);
        peek("t3_last_word", 16'h0F0F);
        drive(1, 0, 1, 0, 1, 0, 1, 16'hFFFE, 16'h0000);

        // stall holds output and blocks writes
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0010, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 1, 1, 0, 1, 16'h0010 + 16'(k * 16), 16'hCAFE);
            peek($sformatf("t4_hold%0d", k), 16'h1234);
        end
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0020, 16'h0000);
        peek("t4_after_stall", 16'hAB66);
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0010, 16'h0000);

        // bypass
        drive(0, 0, 0, 0, 0, 0, 0, 16'hBEEF, 16'h0000);
        peek("t5_bypass", 16'hBEEF);
        drive(1, 0, 0, 0, 0, 0, 0, 16'h1357, 16'h0000);

        // randomised word/byte round trips
        for (int k = 0; k < 8; k++) begin
            logic [15:0] ra;
            logic [15:0] rd;
            ra = {5'd0, 10'($urandom_range(64, 1023)), 1'b0};
            rd = 16'($urandom);
            drive(1, 0, 1, 1, 1, 0, 0, ra, rd);
            drive(1, 0, 1, 0, 1, 0, 1, ra, 16'h0000);
            drive(1, 0, 1, 0, 0, 1'($urandom_range(0, 1)), 1, ra | 16'(k & 1), 16'h0000);
        end

        // async reset mid-cycle
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0010, 16'h0000);
        peek("t6_pre_reset", 16'h1234);
        reset = 1'b0;
        #1;
        chk("t6_rst_ans", ans_dm, 16'h0000);
        chk("t6_rst_valid", valid_dm, 1'b0);
        chk("t6_rst_mis", misalign_err, 1'b0);
        chk("t6_rst_oob", oob_err, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        valid_ex = 1'b0; mem_en_ex = 1'b0; mem_mux_sel_ex = 1'b0;
        drive(1, 0, 1, 0, 1, 0, 1, 16'h0010, 16'h0000);
        peek("t6_ram_kept", 16'h1234);
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
